// File: rtl/pong_core.sv
// Pong game engine: ball and paddle physics, scoring, serve and game-over control
// on the pixel clock, with registered coordinates for the VGA renderer.
module pong_core #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int TICK_DIV    = 312500,
  parameter int PAD_H       = 40,
  parameter int PAD_W       = 10,
  parameter int BALL_R      = 5,
  parameter int WIN_SCORE   = 15,
  parameter int MAX_SPEED   = 4,
  parameter int SERVE_TICKS = 64,
  parameter int AI_REACT    = 260
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PAUSE,
  input  logic       plat1U,
  input  logic       plat1D,
  input  logic       plat2U,
  input  logic       plat2D,
  input  logic       EnableAI1,
  input  logic       EnableAI2,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [9:0] plat1X,
  output logic [9:0] plat2X,
  output logic [9:0] plat1Y,
  output logic [9:0] plat2Y,
  output logic [9:0] plat1H,
  output logic [9:0] plat2H,
  output logic [4:0] Score_1,
  output logic [4:0] Score_2,
  output logic       WIN1,
  output logic       WIN2,
  output logic [1:0] game_state
);

  localparam int W     = 12;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int CNT_W = $clog2(SERVE_TICKS) + 1;

  typedef logic signed [W-1:0] sw_t;
  typedef enum logic [1:0] {KICKOFF = 2'd0, PLAY = 2'd1, SERVE = 2'd2, OVER = 2'd3} state_t;

  localparam sw_t ZERO    = sw_t'(0);
  localparam sw_t ONE     = sw_t'(1);
  localparam sw_t AI_EDGE = sw_t'(5);
  localparam sw_t R       = sw_t'(BALL_R);
  localparam sw_t PH      = sw_t'(PAD_H);
  localparam sw_t PW      = sw_t'(PAD_W);
  localparam sw_t HRES    = sw_t'(H_RES);
  localparam sw_t P1X     = sw_t'(H_RES - 20);
  localparam sw_t P2X     = sw_t'(10);
  localparam sw_t PMAX    = sw_t'(V_RES - 1 - PAD_H);
  localparam sw_t CX      = sw_t'(H_RES / 2);
  localparam sw_t CY      = sw_t'(V_RES / 2);
  localparam sw_t PY0     = sw_t'((V_RES - PAD_H) / 2);
  localparam sw_t YBOT    = sw_t'(V_RES - 1 - BALL_R);
  localparam sw_t XMAX    = sw_t'(H_RES - 1);
  localparam sw_t YMAX    = sw_t'(V_RES - 1);
  localparam sw_t HALF_PH = sw_t'(PAD_H / 2);
  localparam sw_t SRV1_X  = sw_t'(H_RES - 20 - BALL_R - 1);
  localparam sw_t SRV2_X  = sw_t'(10 + PAD_W + BALL_R + 1);
  localparam sw_t MAXSP   = sw_t'(MAX_SPEED);
  localparam sw_t REACT   = sw_t'(AI_REACT);
  localparam logic [4:0]       WIN_M1   = 5'(WIN_SCORE - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] SRV_LAST = CNT_W'(SERVE_TICKS - 1);

  function automatic logic [9:0] clamp10(input sw_t v, input sw_t hi);
    sw_t c;
    c = v;
    if (v < ZERO) c = ZERO;
    else if (v > hi) c = hi;
    return 10'(c);
  endfunction

  function automatic sw_t speed_up(input sw_t s);
    return (s < MAXSP) ? s + ONE : MAXSP;
  endfunction

  function automatic sw_t pad_step(input sw_t p, input logic u, input logic d,
                                   input logic ai_en, input logic ai_act, input sw_t by);
    sw_t n;
    n = p;
    if (ai_en) begin
      if (ai_act) begin
        if (by - R < p + AI_EDGE) begin
          if (p > ONE) n = p - ONE;
        end else if (by + R > p + PH - AI_EDGE) begin
          if (p < PMAX) n = p + ONE;
        end
      end
    end else if (u && !d) begin
      if (p < PMAX) n = p + ONE;
    end else if (d && !u) begin
      if (p > ONE) n = p - ONE;
    end
    return n;
  endfunction

  state_t           state_p0, state_nx;
  logic [DIV_W-1:0] div_p0, div_nx;
  logic [CNT_W-1:0] srv_cnt_p0, srv_cnt_nx;
  sw_t              ball_x_p0, ball_x_nx, ball_y_p0, ball_y_nx;
  sw_t              pad1_y_p0, pad1_nx, pad2_y_p0, pad2_nx;
  sw_t              speed_p0, speed_nx, spd;
  logic [4:0]       score1_p0, score1_nx, score2_p0, score2_nx;
  logic             win1_p0, win1_nx, win2_p0, win2_nx;
  logic             dir_x_p0, dir_x_nx, dir_y_p0, dir_y_nx, dx, dy;
  logic [1:0]       server_p0, server_nx;
  logic             tick, hit1, hit2, ai1_act, ai2_act;

  assign tick = (div_p0 == DIV_LAST);
  assign hit1 = dir_x_p0 && (ball_x_p0 + R >= P1X) && (ball_x_p0 < P1X + PW) &&
                (ball_y_p0 + R >= pad1_y_p0) && (ball_y_p0 - R <= pad1_y_p0 + PH);
  assign hit2 = !dir_x_p0 && (ball_x_p0 - R <= P2X + PW) && (ball_x_p0 > P2X) &&
                (ball_y_p0 + R >= pad2_y_p0) && (ball_y_p0 - R <= pad2_y_p0 + PH);
  assign ai1_act = dir_x_p0 && (P1X - ball_x_p0 <= REACT);
  assign ai2_act = !dir_x_p0 && (ball_x_p0 - (P2X + PW) <= REACT);

  always_comb begin
    state_nx   = state_p0;
    div_nx     = tick ? '0 : div_p0 + DIV_W'(1);
    srv_cnt_nx = srv_cnt_p0;
    ball_x_nx  = ball_x_p0;
    ball_y_nx  = ball_y_p0;
    pad1_nx    = pad1_y_p0;
    pad2_nx    = pad2_y_p0;
    speed_nx   = speed_p0;
    score1_nx  = score1_p0;
    score2_nx  = score2_p0;
    win1_nx    = win1_p0;
    win2_nx    = win2_p0;
    dir_x_nx   = dir_x_p0;
    dir_y_nx   = dir_y_p0;
    server_nx  = server_p0;
    spd        = speed_p0;
    dx         = dir_x_p0;
    dy         = dir_y_p0;
    if (tick) begin
      if (state_p0 != OVER) begin
        pad1_nx = pad_step(pad1_y_p0, plat1U, plat1D, EnableAI1, ai1_act, ball_y_p0);
        pad2_nx = pad_step(pad2_y_p0, plat2U, plat2D, EnableAI2, ai2_act, ball_y_p0);
      end
      unique case (state_p0)
        KICKOFF: begin
          ball_x_nx = CX;
          ball_y_nx = CY;
          if (srv_cnt_p0 == SRV_LAST) begin
            state_nx   = PLAY;
            srv_cnt_nx = '0;
          end else begin
            srv_cnt_nx = srv_cnt_p0 + CNT_W'(1);
          end
        end
        SERVE: begin
          if (server_p0 == 2'd1) begin
            ball_x_nx = SRV1_X;
            ball_y_nx = pad1_y_p0 + HALF_PH;
            dir_x_nx  = 1'b0;
          end else begin
            ball_x_nx = SRV2_X;
            ball_y_nx = pad2_y_p0 + HALF_PH;
            dir_x_nx  = 1'b1;
          end
          if (srv_cnt_p0 == SRV_LAST) begin
            state_nx   = PLAY;
            srv_cnt_nx = '0;
          end else begin
            srv_cnt_nx = srv_cnt_p0 + CNT_W'(1);
          end
        end
        PLAY: begin
          // Hit resolution first so the move uses the bounced direction and new speed.
          if (hit1) begin
            dx  = 1'b0;
            spd = speed_up(speed_p0);
          end else if (hit2) begin
            dx  = 1'b1;
            spd = speed_up(speed_p0);
          end
          if (ball_y_p0 <= R) dy = 1'b1;
          else if (ball_y_p0 >= YBOT) dy = 1'b0;
          dir_x_nx  = dx;
          dir_y_nx  = dy;
          speed_nx  = spd;
          ball_x_nx = dx ? ball_x_p0 + spd : ball_x_p0 - spd;
          ball_y_nx = dy ? ball_y_p0 + ONE : ball_y_p0 - ONE;
          if (!dx && ball_x_p0 <= spd) begin
            score1_nx  = score1_p0 + 5'd1;
            speed_nx   = ONE;
            dir_x_nx   = 1'b0;
            dir_y_nx   = 1'b1;
            server_nx  = 2'd1;
            srv_cnt_nx = '0;
            if (score1_p0 == WIN_M1) begin
              state_nx  = OVER;
              win1_nx   = 1'b1;
              ball_x_nx = CX;
              ball_y_nx = CY;
            end else begin
              state_nx  = SERVE;
              ball_x_nx = SRV1_X;
              ball_y_nx = pad1_y_p0 + HALF_PH;
            end
          end else if (dx && ball_x_p0 + spd >= HRES) begin
            score2_nx  = score2_p0 + 5'd1;
            speed_nx   = ONE;
            dir_x_nx   = 1'b1;
            dir_y_nx   = 1'b0;
            server_nx  = 2'd2;
            srv_cnt_nx = '0;
            if (score2_p0 == WIN_M1) begin
              state_nx  = OVER;
              win2_nx   = 1'b1;
              ball_x_nx = CX;
              ball_y_nx = CY;
            end else begin
              state_nx  = SERVE;
              ball_x_nx = SRV2_X;
              ball_y_nx = pad2_y_p0 + HALF_PH;
            end
          end
        end
        OVER: ;
        default: ;
      endcase
    end
  end

  // Stage p0: game state, advanced only when not paused.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_p0   <= KICKOFF;
      div_p0     <= '0;
      srv_cnt_p0 <= '0;
      ball_x_p0  <= CX;
      ball_y_p0  <= CY;
      pad1_y_p0  <= PY0;
      pad2_y_p0  <= PY0;
      speed_p0   <= ONE;
      score1_p0  <= '0;
      score2_p0  <= '0;
      win1_p0    <= 1'b0;
      win2_p0    <= 1'b0;
      dir_x_p0   <= 1'b1;
      dir_y_p0   <= 1'b1;
      server_p0  <= 2'd0;
    end else if (!PAUSE) begin
      state_p0   <= state_nx;
      div_p0     <= div_nx;
      srv_cnt_p0 <= srv_cnt_nx;
      ball_x_p0  <= ball_x_nx;
      ball_y_p0  <= ball_y_nx;
      pad1_y_p0  <= pad1_nx;
      pad2_y_p0  <= pad2_nx;
      speed_p0   <= speed_nx;
      score1_p0  <= score1_nx;
      score2_p0  <= score2_nx;
      win1_p0    <= win1_nx;
      win2_p0    <= win2_nx;
      dir_x_p0   <= dir_x_nx;
      dir_y_p0   <= dir_y_nx;
      server_p0  <= server_nx;
    end
  end

  // Stage p1: clamped, truncated coordinates for the renderer.
  always_ff @(posedge CLK) begin
    ballX      <= clamp10(ball_x_p0, XMAX);
    ballY      <= clamp10(ball_y_p0, YMAX);
    plat1Y     <= clamp10(pad1_y_p0, YMAX);
    plat2Y     <= clamp10(pad2_y_p0, YMAX);
    Score_1    <= score1_p0;
    Score_2    <= score2_p0;
    WIN1       <= win1_p0;
    WIN2       <= win2_p0;
    game_state <= state_p0;
  end

  assign plat1X = 10'(H_RES - 20);
  assign plat2X = 10'(10);
  assign plat1H = 10'(PAD_H);
  assign plat2H = 10'(PAD_H);

endmodule

// File: tb/tb_pong_core.sv
// Randomized scoreboard bench for pong_core: a velocity-vector game model
// predicts every output cycle; a monitor compares the DUT one clock behind.
module tb_pong_core;
  localparam int H = 640, V = 480, TD = 4, PH = 40, PW = 10, R = 5;
  localparam int WIN = 5, MAXS = 4, ST = 3, REACT = 260;
  localparam int P1X = H - 20, P2X = 10, PMAX = V - 1 - PH;

  logic CLK = 1'b0, RESET = 1'b0, PAUSE = 1'b0;
  logic plat1U = 1'b0, plat1D = 1'b0, plat2U = 1'b0, plat2D = 1'b0;
  logic EnableAI1 = 1'b0, EnableAI2 = 1'b0;
  logic [9:0] ballX, ballY, plat1X, plat2X, plat1Y, plat2Y, plat1H, plat2H;
  logic [4:0] Score_1, Score_2;
  logic WIN1, WIN2;
  logic [1:0] game_state;

  pong_core #(.H_RES(H), .V_RES(V), .TICK_DIV(TD), .PAD_H(PH), .PAD_W(PW), .BALL_R(R),
              .WIN_SCORE(WIN), .MAX_SPEED(MAXS), .SERVE_TICKS(ST), .AI_REACT(REACT)) dut (
    .CLK(CLK), .RESET(RESET), .PAUSE(PAUSE),
    .plat1U(plat1U), .plat1D(plat1D), .plat2U(plat2U), .plat2D(plat2D),
    .EnableAI1(EnableAI1), .EnableAI2(EnableAI2),
    .ballX(ballX), .ballY(ballY), .plat1X(plat1X), .plat2X(plat2X),
    .plat1Y(plat1Y), .plat2Y(plat2Y), .plat1H(plat1H), .plat2H(plat2H),
    .Score_1(Score_1), .Score_2(Score_2), .WIN1(WIN1), .WIN2(WIN2),
    .game_state(game_state));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0] bx, by, p1, p2;
    logic [4:0] s1, s2;
    logic       w1, w2;
    logic [1:0] gs;
  } obs_t;

  obs_t q[$];
  int n_total = 0, n_pass = 0, n_fail = 0;

  // Reference game: ball velocity as a signed vector (vx = +/-speed, vy = +/-1).
  int m_div, m_st, m_bx, m_by, m_vx, m_vy, m_p1, m_p2, m_s1, m_s2, m_w1, m_w2, m_cnt, m_srv;

  task automatic model_reset();
    m_div = 0; m_st = 0; m_bx = H / 2; m_by = V / 2; m_vx = 1; m_vy = 1;
    m_p1 = (V - PH) / 2; m_p2 = (V - PH) / 2; m_s1 = 0; m_s2 = 0;
    m_w1 = 0; m_w2 = 0; m_cnt = 0; m_srv = 0;
  endtask

  function automatic int pad_next(int p, bit u, bit d, bit ai, bit act);
    if (ai) begin
      if (!act) return p;
      if (m_by - R < p + 5) return (p > 1) ? p - 1 : p;
      if (m_by + R > p + PH - 5) return (p < PMAX) ? p + 1 : p;
      return p;
    end
    if (u && !d && p < PMAX) return p + 1;
    if (d && !u && p > 1) return p - 1;
    return p;
  endfunction

  task automatic point(int who);
    m_srv = who; m_cnt = 0;
    if (who == 1) begin
      m_s1++; m_vx = -1; m_vy = 1;
      m_bx = P1X - R - 1; m_by = m_p1 + PH / 2;
      if (m_s1 == WIN) m_w1 = 1;
    end else begin
      m_s2++; m_vx = 1; m_vy = -1;
      m_bx = P2X + PW + R + 1; m_by = m_p2 + PH / 2;
      if (m_s2 == WIN) m_w2 = 1;
    end
    if (m_s1 == WIN || m_s2 == WIN) begin
      m_st = 3; m_bx = H / 2; m_by = V / 2;
    end else m_st = 2;
  endtask

  task automatic model_step(input bit p, u1, d1, u2, d2, a1, a2);
    int np1, np2, sp, fast;
    if (p) return;
    if (m_div != TD - 1) begin
      m_div++;
      return;
    end
    m_div = 0;
    np1 = m_p1; np2 = m_p2;
    if (m_st != 3) begin
      np1 = pad_next(m_p1, u1, d1, a1, (m_vx > 0) && (P1X - m_bx <= REACT));
      np2 = pad_next(m_p2, u2, d2, a2, (m_vx < 0) && (m_bx - (P2X + PW) <= REACT));
    end
    if (m_st == 0 || m_st == 2) begin
      if (m_st == 2) begin
        m_bx = (m_srv == 1) ? P1X - R - 1 : P2X + PW + R + 1;
        m_by = ((m_srv == 1) ? m_p1 : m_p2) + PH / 2;
        m_vx = (m_srv == 1) ? -1 : 1;
      end
      if (m_cnt == ST - 1) begin m_st = 1; m_cnt = 0; end
      else m_cnt++;
    end else if (m_st == 1) begin
      sp = (m_vx < 0) ? -m_vx : m_vx;
      fast = (sp + 1 < MAXS) ? sp + 1 : MAXS;
      if (m_vx > 0 && m_bx + R >= P1X && m_bx < P1X + PW && m_by + R >= m_p1 && m_by - R <= m_p1 + PH)
        m_vx = -fast;
      else if (m_vx < 0 && m_bx - R <= P2X + PW && m_bx > P2X && m_by + R >= m_p2 && m_by - R <= m_p2 + PH)
        m_vx = fast;
      if (m_by <= R) m_vy = 1;
      else if (m_by >= V - 1 - R) m_vy = -1;
      if (m_vx < 0 && m_bx <= -m_vx) point(1);
      else if (m_vx > 0 && m_bx + m_vx >= H) point(2);
      else begin
        m_bx += m_vx;
        m_by += m_vy;
      end
    end
    m_p1 = np1; m_p2 = np2;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.bx = 10'(m_bx); o.by = 10'(m_by); o.p1 = 10'(m_p1); o.p2 = 10'(m_p2);
    o.s1 = 5'(m_s1); o.s2 = 5'(m_s2); o.w1 = m_w1[0]; o.w2 = m_w2[0]; o.gs = 2'(m_st);
    return o;
  endfunction

  task automatic cyc(input bit r, p, u1, d1, u2, d2, a1, a2);
    @(negedge CLK);
    RESET = r; PAUSE = p; plat1U = u1; plat1D = d1; plat2U = u2; plat2D = d2;
    EnableAI1 = a1; EnableAI2 = a2;
    if (!r) model_reset();
    else model_step(p, u1, d1, u2, d2, a1, a2);
    q.push_back(model_obs());
  endtask

  task automatic rnd_cyc(input int pause_pct, input bit ai1, input bit ai2);
    cyc(1'b1, $urandom_range(0, 99) < pause_pct, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ai1, ai2);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin : monitor
    obs_t e, g;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() >= 2) begin
        e = q.pop_front();
        g.bx = ballX; g.by = ballY; g.p1 = plat1Y; g.p2 = plat2Y;
        g.s1 = Score_1; g.s2 = Score_2; g.w1 = WIN1; g.w2 = WIN2; g.gs = game_state;
        n_total++;
        if (g === e) n_pass++;
        else begin
          n_fail++;
          $display("FAIL outputs t=%0t got bx=%0d by=%0d p1=%0d p2=%0d s=%0d/%0d w=%0b%0b st=%0d expected bx=%0d by=%0d p1=%0d p2=%0d s=%0d/%0d w=%0b%0b st=%0d",
                   $time, g.bx, g.by, g.p1, g.p2, g.s1, g.s2, g.w1, g.w2, g.gs,
                   e.bx, e.by, e.p1, e.p2, e.s1, e.s2, e.w1, e.w2, e.gs);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_ballX", ballX, H / 2);
    chk("reset_ballY", ballY, V / 2);
    chk("reset_state", game_state, 0);
    chk("reset_plat1Y", plat1Y, (V - PH) / 2);
    chk("reset_scores", {Score_1, Score_2, WIN1, WIN2}, 0);
    chk("plat1X", plat1X, P1X);
    chk("plat2X", plat2X, P2X);
    chk("platH", {plat1H, plat2H}, {10'(PH), 10'(PH)});

    // Paddle 1 driven up to its stop; paddle 2 given both buttons.
    for (int i = 0; i < 1200 && n_fail < 20; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("plat1Y_stop", plat1Y, PMAX);
    chk("plat2Y_both", plat2Y, (V - PH) / 2);

    for (int i = 0; i < 8000 && n_fail < 20; i++) begin
      if (i == 4000) repeat (100) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      rnd_cyc(2, 1'b1, 1'b1);
    end
    for (int i = 0; i < 4000 && n_fail < 20; i++)
      rnd_cyc(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Paddles parked at the top until someone wins.
    for (int i = 0; i < 50000 && m_st != 3 && n_fail < 20; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if (m_st != 3) begin
      n_total++;
      n_fail++;
      $display("FAIL game_over_timeout: got model state %0d expected 3", m_st);
    end
    for (int i = 0; i < 60 && n_fail < 20; i++) rnd_cyc(5, 1'($urandom_range(0, 1)), 1'b0);
    chk("over_state", game_state, 3);
    chk("over_flags", {WIN1, WIN2}, {m_w1[0], m_w2[0]});
    chk("over_score", (m_w1 != 0) ? Score_1 : Score_2, WIN);
    chk("over_ballX", ballX, H / 2);

    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rereset_state", game_state, 0);
    chk("rereset_flags", {Score_1, Score_2, WIN1, WIN2}, 0);
    chk("rereset_ballY", ballY, V / 2);
    for (int i = 0; i < 200 && n_fail < 20; i++) rnd_cyc(0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
